warp_issue_scheduler: RTL
=========================

WARP_ISSUE_SCHEDULER -- requirements
Module: warp_issue_scheduler

Interface
REQ-001 SHALL use constant NUM_WARP, default 4: number of hardware warps.
REQ-002 SHALL use constant NUM_WARP_LOG, default 2: warp index width.
REQ-003 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port stall_i, input, 1: pipeline stall; freezes all state and outputs.
REQ-006 SHALL have port launch_i, input, 1: one-cycle CTA launch pulse.
REQ-007 SHALL have port warpEnMask_i, input, NUM_WARP: warps participating in the CTA, sampled at launch.
REQ-008 SHALL have port warpReady_i, input, NUM_WARP: per-warp operands ready (scoreboard).
REQ-009 SHALL have port syncDone_i, input, 1: barrier completion from the thread controller.
REQ-010 SHALL have port ctaExit_i, input, 1: warp fully exited, with exitWarp_i (NUM_WARP_LOG).
REQ-011 SHALL have port issueSync_i, input, 1: the warp issued last cycle decoded a barrier.
REQ-012 SHALL have port issueValid_o, output, 1: registered, warp selected this cycle.
REQ-013 SHALL have port issueWarp_o, output, NUM_WARP_LOG: registered, selected warp index.
REQ-014 SHALL have port ctaDone_o, output, 1: registered, one-cycle pulse when all enabled warps exited.

Function
REQ-015 SHALL hold per-warp state: IDLE, ACTIVE, WAIT_BAR, DONE.
REQ-016 SHALL hold a global FSM: S_IDLE -> S_RUN on launch_i; S_RUN -> S_FIN when all enabled warps are DONE; S_FIN -> S_IDLE after one cycle, asserting ctaDone_o.
REQ-017 SHALL, on launch_i in S_IDLE, set enabled warps ACTIVE and disabled warps DONE; launch_i outside S_IDLE SHALL be ignored.
REQ-018 SHALL treat a warp as eligible when it is ACTIVE, warpReady_i is set, and it is not the warp issued in the previous cycle while issueValid_o was high.
REQ-019 SHALL select among eligible warps round-robin, starting at the index after the last issued warp, with wrap-around from NUM_WARP-1 to 0.
REQ-020 SHALL drive issueValid_o=0 when no warp is eligible, keeping the round-robin pointer unchanged.
REQ-021 SHALL move the previously issued warp to WAIT_BAR when issueSync_i=1.
REQ-022 SHALL move all WAIT_BAR warps to ACTIVE on syncDone_i=1. When syncDone_i and issueSync_i occur in the same cycle, the syncing warp SHALL also go ACTIVE.
REQ-023 SHALL move warp exitWarp_i to DONE on ctaExit_i from any state; exit SHALL take priority over sync for the same warp in the same cycle.
REQ-024 SHALL have a selection-to-issueValid_o latency of one cycle.
REQ-025 SHALL, while stall_i=1, hold all state and outputs, and SHALL drop all input events (launch, sync, exit).

Reset
REQ-026 SHALL, on reset, force the FSM to S_IDLE, all warps to IDLE, the pointer to 0, and issueValid_o=0, issueWarp_o=0, ctaDone_o=0.
REQ-027 SHALL let reset asserted mid-CTA abandon the CTA with no ctaDone_o pulse.

Configuration
REQ-028 WARP_SCHED_GREEDY_EN defined: the last issued warp SHALL stay selected while it remains ACTIVE and ready, overriding the back-to-back exclusion of REQ-018. Round-robin SHALL apply only when it is not.
REQ-029 WARP_SCHED_GREEDY_EN undefined: strict round-robin per REQ-018/REQ-019.

Structure
REQ-030 SHALL take NUM_WARP and NUM_WARP_LOG from GPGPUParam.v, and SHALL add the warp-state and FSM encodings there.
REQ-031 SHALL place round-robin selection in sub-module warp_rr_picker (combinational: eligible mask plus pointer to grant index and valid).

Verification
REQ-032 Launch with warpEnMask_i=4'b1111, all ready -> issueWarp_o sequence 0,1,2,3,0.
REQ-033 warpEnMask_i=4'b0101, all ready -> issues alternate 0,2; warps 1 and 3 are never issued.
REQ-034 Warp 1 issues a sync, then syncDone_i 3 cycles later -> warp 1 absent from issue until the cycle after syncDone_i.
REQ-035 ctaExit_i for warps 0..3 in turn -> ctaDone_o pulses exactly once, one cycle after the last exit; the FSM returns to S_IDLE.
REQ-036 stall_i held 5 cycles mid-run -> issueValid_o and issueWarp_o unchanged; sequence resumes where it stopped.
REQ-037 WARP_SCHED_GREEDY_EN defined, all ready -> warp 0 is issued continuously until warpReady_i[0]=0, then warp 1.

Source files
------------

// File: rtl/warp_issue_scheduler_pkg.sv
// Shared constants and encodings for the warp issue scheduler.
// Holds warp count, index width, warp-state and CTA FSM encodings.
package warp_issue_scheduler_pkg;

    localparam int NUM_WARP     = 4;
    localparam int NUM_WARP_LOG = 2;

    typedef logic [NUM_WARP_LOG-1:0] warp_idx_t;

    // Per-warp state
    localparam logic [1:0] W_IDLE     = 2'd0;
    localparam logic [1:0] W_ACTIVE   = 2'd1;
    localparam logic [1:0] W_WAIT_BAR = 2'd2;
    localparam logic [1:0] W_DONE     = 2'd3;

    // CTA-level FSM
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    // (base + off) modulo NUM_WARP, off in [0, NUM_WARP]
    function automatic warp_idx_t wrap_add(
        input warp_idx_t base,
        input int        off
    );
        int s;
        s = int'(base) + off;
        if (s >= NUM_WARP) begin
            s = s - NUM_WARP;
        end
        return warp_idx_t'(s);
    endfunction

endpackage

// File: rtl/warp_rr_picker.sv
// Combinational round-robin picker over the eligible-warp mask.
// Ports: elig_i mask, ptr_i search start -> valid_o, grant_o index.
module warp_rr_picker
    import warp_issue_scheduler_pkg::*;
(
    input  logic [NUM_WARP-1:0] elig_i,
    input  warp_idx_t           ptr_i,
    output logic                valid_o,
    output warp_idx_t           grant_o
);

    // Walk offsets from farthest to nearest so the warp
    // closest to ptr_i is the last (winning) assignment.
    always_comb begin
        valid_o = 1'b0;
        grant_o = ptr_i;
        for (int k = NUM_WARP - 1; k >= 0; k--) begin
            if (elig_i[wrap_add(ptr_i, k)]) begin
                valid_o = 1'b1;
                grant_o = wrap_add(ptr_i, k);
            end
        end
    end

endmodule

// File: rtl/warp_issue_scheduler.sv
// Warp issue scheduler: tracks per-warp CTA state and picks one
// ready warp per cycle, round-robin, with a registered issue port.
// Inputs: clk, reset (sync, high), stall_i, launch_i, warpEnMask_i,
//   warpReady_i, syncDone_i, ctaExit_i, exitWarp_i, issueSync_i.
// Outputs: issueValid_o, issueWarp_o, ctaDone_o (all registered).
// Build option WARP_SCHED_GREEDY_EN: keep re-issuing the last warp
//   while it stays active and ready.
module warp_issue_scheduler
    import warp_issue_scheduler_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_i,
    input  logic                    launch_i,
    input  logic [NUM_WARP-1:0]     warpEnMask_i,
    input  logic [NUM_WARP-1:0]     warpReady_i,
    input  logic                    syncDone_i,
    input  logic                    ctaExit_i,
    input  logic [NUM_WARP_LOG-1:0] exitWarp_i,
    input  logic                    issueSync_i,
    output logic                    issueValid_o,
    output logic [NUM_WARP_LOG-1:0] issueWarp_o,
    output logic                    ctaDone_o
);

    logic [1:0]          fsm_q, fsm_d;
    logic [1:0]          wstate_q [NUM_WARP];
    logic [1:0]          wstate_d [NUM_WARP];
    warp_idx_t           ptr_q, ptr_d;
    logic                issue_valid_q, issue_valid_d;
    warp_idx_t           issue_warp_q, issue_warp_d;
    logic                cta_done_q, cta_done_d;

    logic [NUM_WARP-1:0] elig;
    logic [NUM_WARP-1:0] sync_hit;
    logic                pick_valid;
    warp_idx_t           pick_idx;
    logic                stick;
    logic                sel_valid;
    warp_idx_t           sel_warp;
    logic                all_done;

    // The warp on the issue port right now was picked last cycle;
    // it is the one excluded from back-to-back issue and the one
    // a barrier report refers to.
    always_comb begin
        elig     = '0;
        sync_hit = '0;
        for (int i = 0; i < NUM_WARP; i++) begin
            elig[i] = (wstate_q[i] == W_ACTIVE)
                   && warpReady_i[i]
                   && !(issue_valid_q
                        && issue_warp_q == warp_idx_t'(i));
            sync_hit[i] = issueSync_i
                       && issue_valid_q
                       && issue_warp_q == warp_idx_t'(i)
                       && (wstate_q[i] == W_ACTIVE);
        end
    end

    warp_rr_picker u_picker (
        .elig_i  (elig),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .grant_o (pick_idx)
    );

`ifdef WARP_SCHED_GREEDY_EN
    assign stick = issue_valid_q
                && (wstate_q[issue_warp_q] == W_ACTIVE)
                && warpReady_i[issue_warp_q];
`else
    assign stick = 1'b0;
`endif

    assign sel_valid = stick | pick_valid;
    assign sel_warp  = stick ? issue_warp_q : pick_idx;

    always_comb begin
        fsm_d         = fsm_q;
        wstate_d      = wstate_q;
        ptr_d         = ptr_q;
        issue_valid_d = issue_valid_q;
        issue_warp_d  = issue_warp_q;
        cta_done_d    = cta_done_q;
        all_done      = 1'b0;
        if (!stall_i) begin
            issue_valid_d = sel_valid;
            cta_done_d    = 1'b0;
            if (sel_valid) begin
                issue_warp_d = sel_warp;
                ptr_d        = wrap_add(sel_warp, 1);
            end
            unique case (1'b1)
                (fsm_q == S_IDLE): begin
                    if (launch_i) begin
                        for (int i = 0; i < NUM_WARP; i++) begin
                            wstate_d[i] = warpEnMask_i[i]
                                        ? W_ACTIVE : W_DONE;
                        end
                        fsm_d = S_RUN;
                    end
                end
                (fsm_q == S_RUN): begin
                    // Later assignments win: exit over sync,
                    // barrier release over a same-cycle barrier.
                    for (int i = 0; i < NUM_WARP; i++) begin
                        if (syncDone_i
                            && wstate_q[i] == W_WAIT_BAR) begin
                            wstate_d[i] = W_ACTIVE;
                        end
                        if (sync_hit[i] && !syncDone_i) begin
                            wstate_d[i] = W_WAIT_BAR;
                        end
                        if (ctaExit_i
                            && exitWarp_i == warp_idx_t'(i)) begin
                            wstate_d[i] = W_DONE;
                        end
                    end
                    all_done = 1'b1;
                    for (int i = 0; i < NUM_WARP; i++) begin
                        if (wstate_d[i] != W_DONE) begin
                            all_done = 1'b0;
                        end
                    end
                    if (all_done) begin
                        fsm_d      = S_FIN;
                        cta_done_d = 1'b1;
                    end
                end
                (fsm_q == S_FIN): begin
                    fsm_d = S_IDLE;
                    for (int i = 0; i < NUM_WARP; i++) begin
                        wstate_d[i] = W_IDLE;
                    end
                end
                default: begin
                    fsm_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q         <= S_IDLE;
            ptr_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_warp_q  <= '0;
            cta_done_q    <= 1'b0;
            for (int i = 0; i < NUM_WARP; i++) begin
                wstate_q[i] <= W_IDLE;
            end
        end else begin
            fsm_q         <= fsm_d;
            ptr_q         <= ptr_d;
            issue_valid_q <= issue_valid_d;
            issue_warp_q  <= issue_warp_d;
            cta_done_q    <= cta_done_d;
            for (int i = 0; i < NUM_WARP; i++) begin
                wstate_q[i] <= wstate_d[i];
            end
        end
    end

    assign issueValid_o = issue_valid_q;
    assign issueWarp_o  = issue_warp_q;
    assign ctaDone_o    = cta_done_q;

endmodule
